fpga_rst_strap_ctrl: RTL
========================

// Module: fpga_rst_strap_ctrl
// PURPOSE
//  Reset and strap sequencer for FPGA top levels. Waits for clock-generator lock,
//  samples the JTAG/SPI select and bootstrap strap pads, and debounces them.
//  It then latches the strap values and releases system reset after a fixed hold.
//  It also handles the JTAG SRST request and loss of lock, so the core never
//  leaves reset on unstable clocks or straps.
// PARAMETERS
//  DebounceCycles  16  consecutive stable cycles needed before straps latch (>=2)
//  HoldCycles      32  cycles sys_rst_no stays low after latch (>=1)
//  SyncStages      2   flop stages on every asynchronous input (>=2)
// PORTS
//  clk_i              in   1  system clock
//  rst_i              in   1  synchronous, active-high reset
//  pll_locked_i       in   1  clock generator lock (async)
//  srst_ni            in   1  JTAG system reset request, active-low (async)
//  strap_spi_i        in   1  debug select pad: 0=JTAG, 1=SPI (async)
//  strap_boot_i       in   1  bootstrap pad: 1=bootstrap (async)
//  sys_rst_no         out  1  system reset to core, active-low
//  strap_valid_o      out  1  latched strap outputs are valid
//  strap_sel_spi_o    out  1  latched debug select
//  strap_bootstrap_o  out  1  latched bootstrap request
//  state_o            out  2  FSM state: 0=WAIT_LOCK 1=SAMPLE 2=HOLD 3=RUN
// BEHAVIOUR
//  - Async inputs pass through SyncStages-flop synchronizers, which are cleared on rst_i.
//    Synchronizers reset to 0 for pll_locked/straps and 1 for srst_ni.
//    All decisions below use the synced values (pll_lk, srst_n, spi_s, boot_s).
//  - Reset (rst_i=1): state=WAIT_LOCK, sys_rst_no=0, strap_valid_o=0,
//    strap_sel_spi_o=0, strap_bootstrap_o=0, counters=0. All outputs are registered.
//  - WAIT_LOCK: sys_rst_no=0. When pll_lk=1 and srst_n=1, go to SAMPLE and clear dbcnt.
//  - SAMPLE: each cycle, compare {spi_s,boot_s} with the previous-cycle sample.
//    On a difference, dbcnt=0. Otherwise dbcnt++, saturating at DebounceCycles-1.
//    When the current sample equals the previous one and dbcnt==DebounceCycles-1:
//    latch strap_sel_spi_o/strap_bootstrap_o from the current sample,
//    set strap_valid_o=1 the next cycle, clear hcnt, and go to HOLD.
//    Minimum SAMPLE residency is DebounceCycles cycles.
//  - HOLD: sys_rst_no=0. hcnt++ each cycle. At hcnt==HoldCycles-1, go to RUN.
//    sys_rst_no goes to 1 on the first RUN cycle (exactly HoldCycles cycles in HOLD).
//  - RUN: sys_rst_no=1. Straps are held and pad changes are ignored.
//  - srst_n=0 in SAMPLE/HOLD/RUN: next state is WAIT_LOCK and sys_rst_no=0 next cycle.
//    strap_valid_o=0 and counters clear. Latched strap values are kept but invalid.
//    Straps are re-sampled once srst_n returns to 1.
//  - pll_lk=0 in any state: same action as srst, into WAIT_LOCK.
//  - Simultaneous lock loss and srst: identical result, with no priority conflict.
//    Both take priority over every SAMPLE/HOLD progress transition in the same cycle.
//  - rst_i mid-sequence: immediate return to reset values on the next edge.
//  - Counters are sized $clog2 of their limit and never wrap: dbcnt saturates,
//    and hcnt stops at its terminal count on exit.
//  - state_o is the encoded current state register.
// TESTING
//  1 Defaults; straps spi=1/boot=0 held static; lock at cycle 10 -> SAMPLE at 10+2+1.
//    strap_valid_o=1 after 16 stable cycles; sys_rst_no=1 exactly 32 cycles later;
//    outputs spi=1, boot=0.
//  2 boot toggles every 5 cycles for 40 cycles, then stable at 1
//    -> no latch during toggling; latch 16 cycles after last edge with boot=1.
//  3 In RUN, drop pll_locked_i for 1 cycle -> sys_rst_no=0 and strap_valid_o=0
//    within 3 cycles; full SAMPLE+HOLD replays once relocked.
//  4 In HOLD at hcnt=10, pulse srst_ni low 4 cycles -> WAIT_LOCK and straps
//    re-sampled; new strap values (spi 1->0) reflected in outputs.
//  5 Assert rst_i in SAMPLE with dbcnt=12 -> all outputs at reset values next cycle;
//    sequence restarts from WAIT_LOCK.
//  6 Straps change while in RUN -> strap_* outputs and sys_rst_no unchanged
//    (check 100 cycles).

Source files
------------

// File: rtl/fpga_rst_strap_ctrl.sv
// Reset and strap sequencer: waits for clock lock, debounces the strap pads,
// latches them, then releases core reset after a fixed hold.
module fpga_rst_strap_ctrl #(
  parameter int DebounceCycles = 16,
  parameter int HoldCycles     = 32,
  parameter int SyncStages     = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pll_locked_i,
  input  logic       srst_ni,
  input  logic       strap_spi_i,
  input  logic       strap_boot_i,
  output logic       sys_rst_no,
  output logic       strap_valid_o,
  output logic       strap_sel_spi_o,
  output logic       strap_bootstrap_o,
  output logic [1:0] state_o
);

  localparam int DbW = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
  localparam int HW  = (HoldCycles > 1) ? $clog2(HoldCycles) : 1;
  localparam logic [DbW-1:0] DbLast = DbW'(DebounceCycles - 1);
  localparam logic [HW-1:0]  HLast  = HW'(HoldCycles - 1);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_SAMPLE    = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  logic [SyncStages-1:0] r_lk_sync, r_srst_sync, r_spi_sync, r_boot_sync;
  logic                  w_pll_lk, w_srst_n, w_abort, w_latch;
  logic [1:0]            w_smp, r_prev;
  state_t                r_state, w_state_nxt;
  logic [DbW-1:0]        r_dbcnt, w_dbcnt_nxt;
  logic [HW-1:0]         r_hcnt, w_hcnt_nxt;
  logic                  r_rst_n, r_valid, r_spi, r_boot;

  // Synchronizer stage: srst_n clears to the inactive level so reset alone never looks like a request
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lk_sync   <= '0;
      r_srst_sync <= '1;
      r_spi_sync  <= '0;
      r_boot_sync <= '0;
      r_prev      <= '0;
    end else begin
      r_lk_sync   <= {r_lk_sync[SyncStages-2:0], pll_locked_i};
      r_srst_sync <= {r_srst_sync[SyncStages-2:0], srst_ni};
      r_spi_sync  <= {r_spi_sync[SyncStages-2:0], strap_spi_i};
      r_boot_sync <= {r_boot_sync[SyncStages-2:0], strap_boot_i};
      r_prev      <= w_smp;
    end
  end

  assign w_pll_lk = r_lk_sync[SyncStages-1];
  assign w_srst_n = r_srst_sync[SyncStages-1];
  assign w_smp    = {r_spi_sync[SyncStages-1], r_boot_sync[SyncStages-1]};
  assign w_abort  = !w_pll_lk || !w_srst_n;

  always_comb begin
    w_state_nxt = r_state;
    w_dbcnt_nxt = r_dbcnt;
    w_hcnt_nxt  = r_hcnt;
    w_latch     = 1'b0;
    if (w_abort) begin
      w_state_nxt = ST_WAIT_LOCK;
      w_dbcnt_nxt = '0;
      w_hcnt_nxt  = '0;
    end else begin
      case (r_state)
        ST_WAIT_LOCK: begin
          w_state_nxt = ST_SAMPLE;
          w_dbcnt_nxt = '0;
          w_hcnt_nxt  = '0;
        end
        ST_SAMPLE: begin
          if (w_smp != r_prev) begin
            w_dbcnt_nxt = '0;
          end else if (r_dbcnt == DbLast) begin
            w_latch     = 1'b1;
            w_state_nxt = ST_HOLD;
            w_hcnt_nxt  = '0;
          end else begin
            w_dbcnt_nxt = r_dbcnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (r_hcnt == HLast) w_state_nxt = ST_RUN;
          else                 w_hcnt_nxt  = r_hcnt + 1'b1;
        end
        ST_RUN:  ;
        default: w_state_nxt = ST_WAIT_LOCK;
      endcase
    end
  end

  // Output stage: registered from next state so reset release lands on the first RUN cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_WAIT_LOCK;
      r_dbcnt <= '0;
      r_hcnt  <= '0;
      r_rst_n <= 1'b0;
      r_valid <= 1'b0;
      r_spi   <= 1'b0;
      r_boot  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dbcnt <= w_dbcnt_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_rst_n <= (w_state_nxt == ST_RUN);
      r_valid <= (w_state_nxt == ST_HOLD) || (w_state_nxt == ST_RUN);
      if (w_latch) begin
        r_spi  <= w_smp[1];
        r_boot <= w_smp[0];
      end
    end
  end

  assign sys_rst_no        = r_rst_n;
  assign strap_valid_o     = r_valid;
  assign strap_sel_spi_o   = r_spi;
  assign strap_bootstrap_o = r_boot;
  assign state_o           = r_state;

endmodule
